// File: rtl/bench_run_ctrl.sv
// Benchmark run sequencer: resets and releases the cpu core, counts run cycles until a halt store or timeout,
// then freezes the core and streams RESULT_WORDS dmem words to a ready/valid sink.
module bench_run_ctrl #(
    parameter int unsigned RST_CYCLES   = 2,
    parameter logic [31:0] HALT_ADDR    = 32'h3FC,
    parameter int unsigned RESULT_BASE  = 0,
    parameter int unsigned RESULT_WORDS = 4,
    parameter int unsigned AW           = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   max_cycles,
    output logic          cpu_reset,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic [7:0]    res_index,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [31:0]   cycles
);

    localparam int unsigned   HW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_END = HW'(RST_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX = 8'(RESULT_WORDS - 1);
    localparam logic [AW-1:0] BASE_A   = AW'(RESULT_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RUN, S_RDREQ, S_RDWAIT, S_PRESENT, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [31:0]   max_q, max_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    res_index_q, res_index_d;
    logic [31:0]   res_data_q, res_data_d;

    logic [31:0] cycles_inc;
    logic        halt_hit;
    logic        start_ok;

    assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    assign halt_hit   = cpu_we && (cpu_addr == HALT_ADDR);
    assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycles_d    = cycles_q;
        max_d       = max_q;
        timeout_d   = timeout_q;
        res_index_d = res_index_q;
        res_data_d  = res_data_q;

        if (abort) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d     = S_HOLD;
            hold_cnt_d  = '0;
            cycles_d    = '0;
            timeout_d   = 1'b0;
            max_d       = max_cycles;
            res_index_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                    if (hold_cnt_q == HOLD_END) state_d = S_RUN;
                end
                S_RUN: begin
                    cycles_d = cycles_inc;
                    // A halt store in the same cycle as the limit is a normal completion.
                    if (halt_hit) begin
                        state_d = S_RDREQ;
                    end else if ((max_q != 32'd0) && (cycles_inc == max_q)) begin
                        timeout_d = 1'b1;
                        state_d   = S_RDREQ;
                    end
                end
                S_RDREQ:  state_d = S_RDWAIT;
                S_RDWAIT: begin
                    res_data_d = rd_data;
                    state_d    = S_PRESENT;
                end
                S_PRESENT: begin
                    if (res_ready) begin
                        if (res_index_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            res_index_d = res_index_q + 8'd1;
                            state_d     = S_RDREQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            cycles_q    <= '0;
            max_q       <= '0;
            timeout_q   <= 1'b0;
            res_index_q <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycles_q    <= cycles_d;
            max_q       <= max_d;
            timeout_q   <= timeout_d;
            res_index_q <= res_index_d;
            res_data_q  <= res_data_d;
        end
    end

    // The core only runs in RUN; it stays frozen through readback so dmem is stable.
    assign cpu_reset = (state_q != S_RUN);
    assign rd_en     = (state_q == S_RDREQ);
    assign rd_addr   = BASE_A + AW'(res_index_q);
    assign res_valid = (state_q == S_PRESENT);
    assign res_data  = res_data_q;
    assign res_index = res_index_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;

endmodule
